alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Picks one requester per open cycle, drives its operation to the ALU, and
// holds the result in a single-entry register until the owner consumes it.
module alu_arbiter #(
    parameter int unsigned CNT_W = 16,
    parameter bit          RR_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [31:0]      req0_op1_i,
    input  logic [31:0]      req0_op2_i,
    input  logic [3:0]       req0_ctrl_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [31:0]      req1_op1_i,
    input  logic [31:0]      req1_op2_i,
    input  logic [3:0]       req1_ctrl_i,

    output logic [31:0]      alu_operand1_o,
    output logic [31:0]      alu_operand2_o,
    output logic [3:0]       alu_control_o,
    input  logic [31:0]      alu_result_i,
    input  logic             alu_zero_i,

    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic             rsp_zero_o,

    output logic [CNT_W-1:0] grant_cnt0_o,
    output logic [CNT_W-1:0] grant_cnt1_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;     // 0: requester 0 owns the held result
    logic               rr_ptr_q, rr_ptr_d;   // 1: requester 1 wins the next tie
    logic [DATA_W-1:0]  result_q, result_d;
    logic               zero_q, zero_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    logic               owner_ready;
    logic               open_cycle;
    logic               gnt0;
    logic               gnt1;

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    // Arbitration, ALU drive and next-state logic.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        result_d       = result_q;
        zero_d         = zero_q;
        cnt0_d         = cnt0_q;
        cnt1_d         = cnt1_q;
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        alu_operand1_o = '0;
        alu_operand2_o = '0;
        alu_control_o  = '0;

        owner_ready = owner_q ? rsp1_ready_i : rsp0_ready_i;
        // Requests presented while reset is high are never accepted.
        open_cycle  = !rst_i && ((state_q == ST_IDLE) || owner_ready);

        if (open_cycle) begin
            if (req0_valid_i && req1_valid_i) begin
                if (RR_EN && rr_ptr_q) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else begin
                gnt0 = req0_valid_i;
                gnt1 = req1_valid_i;
            end
        end

        if (gnt0 || gnt1) begin
            alu_operand1_o = gnt1 ? req1_op1_i  : req0_op1_i;
            alu_operand2_o = gnt1 ? req1_op2_i  : req0_op2_i;
            alu_control_o  = gnt1 ? req1_ctrl_i : req0_ctrl_i;
            result_d       = alu_result_i;
            zero_d         = alu_zero_i;
            owner_d        = gnt1;
            rr_ptr_d       = gnt0;
            state_d        = ST_HOLD;
            if (gnt0 && (cnt0_q != {CNT_W{1'b1}})) begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end
            if (gnt1 && (cnt1_q != {CNT_W{1'b1}})) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end
        end else if ((state_q == ST_HOLD) && owner_ready) begin
            state_d = ST_IDLE;
        end
    end

    // Handshake and held-result outputs.
    always_comb begin
        req0_ready_o = gnt0;
        req1_ready_o = gnt1;
        rsp0_valid_o = (state_q == ST_HOLD) && !owner_q;
        rsp1_valid_o = (state_q == ST_HOLD) && owner_q;
        rsp_result_o = result_q;
        rsp_zero_o   = zero_q;
        grant_cnt0_o = cnt0_q;
        grant_cnt1_o = cnt1_q;
    end

    // Width marker kept for readability of the control path.
    logic [CTRL_W-1:0] unused_ctrl_w;
    assign unused_ctrl_w = alu_control_o;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance with default counters
// and a fixed-priority instance with 2-bit counters share one stimulus stream.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        v0, v1, r0, r1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  c0, c1;

    // round-robin instance
    logic        m_rdy0, m_rdy1, m_rv0, m_rv1, m_rz, m_az;
    logic [31:0] m_op1, m_op2, m_res, m_ar;
    logic [3:0]  m_ctl;
    logic [15:0] m_cnt0, m_cnt1;

    // fixed-priority instance
    logic        f_rdy0, f_rdy1, f_rv0, f_rv1, f_rz, f_az;
    logic [31:0] f_op1, f_op2, f_res, f_ar;
    logic [3:0]  f_ctl;
    logic [1:0]  f_cnt0, f_cnt1;

    int checks   = 0;
    int failures = 0;

    // Reference model of the shared ALU that sits outside the arbiter.
    function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] c);
        case (c)
            4'd0:    return x & y;
            4'd1:    return x | y;
            4'd2:    return x + y;
            4'd3:    return x - y;
            4'd4:    return x ^ y;
            4'd5:    return x << y[4:0];
            4'd6:    return x >> y[4:0];
            4'd7:    return {31'd0, (x < y)};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign m_ar = alu_f(m_op1, m_op2, m_ctl);
    assign m_az = (m_ar == 32'd0);
    assign f_ar = alu_f(f_op1, f_op2, f_ctl);
    assign f_az = (f_ar == 32'd0);

    alu_arbiter u_dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(m_rdy0), .req0_op1_i(a0), .req0_op2_i(b0), .req0_ctrl_i(c0),
        .req1_valid_i(v1), .req1_ready_o(m_rdy1), .req1_op1_i(a1), .req1_op2_i(b1), .req1_ctrl_i(c1),
        .alu_operand1_o(m_op1), .alu_operand2_o(m_op2), .alu_control_o(m_ctl),
        .alu_result_i(m_ar), .alu_zero_i(m_az),
        .rsp0_valid_o(m_rv0), .rsp0_ready_i(r0), .rsp1_valid_o(m_rv1), .rsp1_ready_i(r1),
        .rsp_result_o(m_res), .rsp_zero_o(m_rz),
        .grant_cnt0_o(m_cnt0), .grant_cnt1_o(m_cnt1)
    );

    alu_arbiter #(.CNT_W(2), .RR_EN(1'b0)) u_fp (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(f_rdy0), .req0_op1_i(a0), .req0_op2_i(b0), .req0_ctrl_i(c0),
        .req1_valid_i(v1), .req1_ready_o(f_rdy1), .req1_op1_i(a1), .req1_op2_i(b1), .req1_ctrl_i(c1),
        .alu_operand1_o(f_op1), .alu_operand2_o(f_op2), .alu_control_o(f_ctl),
        .alu_result_i(f_ar), .alu_zero_i(f_az),
        .rsp0_valid_o(f_rv0), .rsp0_ready_i(r0), .rsp1_valid_o(f_rv1), .rsp1_ready_i(r1),
        .rsp_result_o(f_res), .rsp_zero_o(f_rz),
        .grant_cnt0_o(f_cnt0), .grant_cnt1_o(f_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and apply a new request pair.
    task automatic drive(input logic nv0, input logic [3:0] nc0, input logic [31:0] na0, input logic [31:0] nb0,
                         input logic nv1, input logic [3:0] nc1, input logic [31:0] na1, input logic [31:0] nb1);
        @(posedge clk);
        #1;
        v0 = nv0; c0 = nc0; a0 = na0; b0 = nb0;
        v1 = nv1; c1 = nc1; a1 = na1; b1 = nb1;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    // expected main-instance grant per tie cycle and result per owner
    logic exp_tie [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; r0 = 1'b1; r1 = 1'b1;
        v0 = 1'b0; v1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; c0 = '0; c1 = '0;
        repeat (2) @(posedge clk);

        // request during reset is ignored, outputs quiet
        drive(1'b1, 4'd2, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("rst_rdy0", 32'(m_rdy0), 32'd0);
        check("rst_rv0", 32'(m_rv0), 32'd0);
        check("rst_op1", m_op1, 32'd0);
        check("rst_cnt0", 32'(m_cnt0), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single ADD 5+7 from requester 0
        @(negedge clk);
        check("add_rdy0", 32'(m_rdy0), 32'd1);
        check("add_rdy1", 32'(m_rdy1), 32'd0);
        check("add_op1", m_op1, 32'd5);
        check("add_ctl", 32'(m_ctl), 32'd2);
        idle();
        @(negedge clk);
        check("add_rv0", 32'(m_rv0), 32'd1);
        check("add_rv1", 32'(m_rv1), 32'd0);
        check("add_res", m_res, 32'd12);
        check("add_zero", 32'(m_rz), 32'd0);
        check("idle_op1", m_op1, 32'd0);
        check("add_cnt0", 32'(m_cnt0), 32'd1);

        // backpressure: SUB 9-9 for requester 1, owner stalls three cycles
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd3, 32'd9, 32'd9);
        @(negedge clk);
        check("sub_rdy1", 32'(m_rdy1), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd0, 32'hF0F0, 32'hFF00, 1'b0, 4'd0, 32'd0, 32'd0);
            r1 = 1'b0;
            @(negedge clk);
            check("bp_rv1", 32'(m_rv1), 32'd1);
            check("bp_res", m_res, 32'd0);
            check("bp_zero", 32'(m_rz), 32'd1);
            check("bp_rdy0", 32'(m_rdy0), 32'd0);
            check("bp_rv0", 32'(m_rv0), 32'd0);
        end
        @(posedge clk);
        #1 r1 = 1'b1;
        @(negedge clk);
        check("rel_rdy0", 32'(m_rdy0), 32'd1);
        check("rel_rv1", 32'(m_rv1), 32'd1);
        idle();
        @(negedge clk);
        check("and_rv0", 32'(m_rv0), 32'd1);
        check("and_res", m_res, 32'h0000_F000);
        check("bp_cnt1", 32'(m_cnt1), 32'd1);

        // reset while requester 0 holds a result
        drive(1'b1, 4'd1, 32'h10, 32'h01, 1'b0, 4'd0, 32'd0, 32'd0);
        idle();
        r0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_rv0", 32'(m_rv0), 32'd1);
        check("pre_rst_res", m_res, 32'h11);
        @(posedge clk);
        #1 rst = 1'b0; r0 = 1'b1;
        @(negedge clk);
        check("mrst_rv0", 32'(m_rv0), 32'd0);
        check("mrst_rv1", 32'(m_rv1), 32'd0);
        check("mrst_rdy0", 32'(m_rdy0), 32'd0);
        check("mrst_cnt0", 32'(m_cnt0), 32'd0);
        check("mrst_cnt1", 32'(m_cnt1), 32'd0);
        check("mrst_fcnt0", 32'(f_cnt0), 32'd0);

        // four-cycle tie: RR alternates starting at 0, fixed priority always 0
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd2, 32'd1, 32'd2, 1'b1, 4'd3, 32'd10, 32'd4);
            @(negedge clk);
            check("tie_rdy0", 32'(m_rdy0), 32'(!exp_tie[i]));
            check("tie_rdy1", 32'(m_rdy1), 32'(exp_tie[i]));
            check("fp_rdy0", 32'(f_rdy0), 32'd1);
            check("fp_rdy1", 32'(f_rdy1), 32'd0);
            if (i > 0) begin
                check("tie_rv1", 32'(m_rv1), 32'(exp_tie[i-1]));
                check("tie_res", m_res, exp_tie[i-1] ? 32'd6 : 32'd3);
            end
        end

        // lone request from 1 wins despite the pointer favouring 0; SLTU 3<5
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd7, 32'd3, 32'd5);
        @(negedge clk);
        check("lone_rdy1", 32'(m_rdy1), 32'd1);
        check("lone_res", m_res, 32'd6);
        check("tie_cnt0", 32'(m_cnt0), 32'd2);
        check("tie_cnt1", 32'(m_cnt1), 32'd2);

        // undefined control code forwarded unchanged
        drive(1'b1, 4'hA, 32'd1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("fwd_ctl", 32'(m_ctl), 32'hA);
        check("sltu_rv1", 32'(m_rv1), 32'd1);
        check("sltu_res", m_res, 32'd1);
        idle();
        @(negedge clk);
        check("fwd_res", m_res, 32'hDEAD_BEEF);
        check("fwd_rv0", 32'(m_rv0), 32'd1);
        check("end_cnt0", 32'(m_cnt0), 32'd3);
        check("end_cnt1", 32'(m_cnt1), 32'd3);
        check("sat_fcnt0", 32'(f_cnt0), 32'd3);
        check("sat_fcnt1", 32'(f_cnt1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
